// File: rtl/game_flow_ctl.sv
// game_flow_ctl
//   Match sequencer for the pong-style game in the 65 MHz VGA domain.
//   Chooses which screen is drawn (idle menu, single-player or multi-player).
//   Holds the ball before each serve and pauses it after each point.
//   Keeps one score per player and declares a winner at WIN_SCORE.
//
// Ports
//   clk65MHz      pixel clock, the only clock
//   rst           asynchronous reset, active low
//   frame_tick    one-cycle pulse per frame
//   mode_sel      0 idle, 1 single, 2 multi, 3 treated as idle
//   start         switch level; a rising edge starts a match or acknowledges game over
//   point_valid   one-cycle pulse: point_player has scored
//   point_player  index of the scoring player
//   screen_idle / screen_single / screen_multi   one-hot screen select
//   ball_enable   ball may move (PLAY only)
//   serve_player  player who serves next
//   score         packed scores, player i at [i*SCORE_W +: SCORE_W]
//   game_over     match finished; winner is valid while this is high
//   winner        index of the winning player
//   state_dbg     state encoding: IDLE 0, SERVE 1, PLAY 2, POINT 3, OVER 4
module game_flow_ctl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    localparam int PW          = $clog2(NUM_PLAYERS)
) (
    input  logic                           clk65MHz,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic [1:0]                     mode_sel,
    input  logic                           start,
    input  logic                           point_valid,
    input  logic [PW-1:0]                  point_player,
    output logic                           screen_idle,
    output logic                           screen_single,
    output logic                           screen_multi,
    output logic                           ball_enable,
    output logic [PW-1:0]                  serve_player,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           game_over,
    output logic [PW-1:0]                  winner,
    output logic [2:0]                     state_dbg
);

    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic [CNT_W-1:0]   frame_cnt, cnt_nxt;
    logic [SCORE_W-1:0] score_r   [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_nxt [NUM_PLAYERS];
    logic [SCORE_W-1:0] new_score;
    logic [PW-1:0]      serve_nxt, winner_nxt;
    logic               start_q, armed;
    logic               start_edge, mode_ok, player_ok;

    // armed stays low until start has been seen low once after reset, so a
    // switch already up when reset releases never counts as a start.
    assign start_edge = start & ~start_q & armed;
    assign mode_ok    = (mode_sel == 2'd1) || (mode_sel == 2'd2);
    assign player_ok  = {1'b0, point_player} < (PW+1)'(NUM_PLAYERS);
    assign new_score  = score_r[point_player] + SCORE_W'(1);

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        cnt_nxt    = frame_cnt;
        score_nxt  = score_r;
        serve_nxt  = serve_player;
        winner_nxt = winner;
        case (state)
            S_IDLE: begin
                if (start_edge && mode_ok) begin
                    state_nxt  = S_SERVE;
                    mode_nxt   = mode_sel;
                    cnt_nxt    = '0;
                    serve_nxt  = '0;
                    winner_nxt = '0;
                    for (int i = 0; i < NUM_PLAYERS; i++) score_nxt[i] = '0;
                end
            end
            S_SERVE: begin
                if (!mode_ok) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (frame_tick) begin
                    if (frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_nxt = S_PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                // Abort wins over a coincident point; the counter is not
                // touched by frame_tick here, so a tick arriving with the
                // point is never counted in POINT.
                if (!mode_ok) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (point_valid && player_ok &&
                             score_r[point_player] != SCORE_W'(WIN_SCORE)) begin
                    score_nxt[point_player] = new_score;
                    serve_nxt = (point_player == PW'(NUM_PLAYERS - 1)) ? '0
                                                                        : point_player + PW'(1);
                    cnt_nxt   = '0;
                    if (new_score == SCORE_W'(WIN_SCORE)) begin
                        state_nxt  = S_OVER;
                        winner_nxt = point_player;
                    end else begin
                        state_nxt = S_POINT;
                    end
                end
            end
            S_POINT: begin
                if (!mode_ok) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (frame_tick) begin
                    if (frame_cnt == CNT_W'(POINT_FRAMES - 1)) begin
                        state_nxt = S_SERVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (start_edge) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are true registers
    // that move in the same cycle as the state itself.
    always_ff @(posedge clk65MHz or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            mode_q        <= 2'd0;
            frame_cnt     <= '0;
            start_q       <= 1'b0;
            armed         <= 1'b0;
            serve_player  <= '0;
            winner        <= '0;
            screen_idle   <= 1'b1;
            screen_single <= 1'b0;
            screen_multi  <= 1'b0;
            ball_enable   <= 1'b0;
            game_over     <= 1'b0;
            state_dbg     <= 3'd0;
            for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= '0;
        end else begin
            state         <= state_nxt;
            mode_q        <= mode_nxt;
            frame_cnt     <= cnt_nxt;
            start_q       <= start;
            armed         <= armed | ~start;
            serve_player  <= serve_nxt;
            winner        <= winner_nxt;
            screen_idle   <= (state_nxt == S_IDLE) || (state_nxt == S_OVER);
            screen_single <= (state_nxt != S_IDLE) && (state_nxt != S_OVER) && (mode_nxt == 2'd1);
            screen_multi  <= (state_nxt != S_IDLE) && (state_nxt != S_OVER) && (mode_nxt == 2'd2);
            ball_enable   <= (state_nxt == S_PLAY);
            game_over     <= (state_nxt == S_OVER);
            state_dbg     <= state_nxt;
            for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= score_nxt[i];
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        assign score[g*SCORE_W +: SCORE_W] = score_r[g];
    end

endmodule

// File: tb/tb_game_flow_ctl.sv
// Testbench for game_flow_ctl with three players (so an out-of-range player
// index exists). Stimulus goes through drive(), which also advances a
// behavioural model and queues the expected outputs; a monitor pops one
// expectation per clock and compares it with the DUT.
module tb_game_flow_ctl;

    localparam int NP  = 3;
    localparam int SW  = 4;
    localparam int WIN = 11;
    localparam int SF  = 60;
    localparam int PF  = 90;

    localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            frame_tick = 1'b0;
    logic [1:0]      mode_sel = 2'd0;
    logic            start = 1'b0;
    logic            point_valid = 1'b0;
    logic [1:0]      point_player = 2'd0;
    logic            screen_idle, screen_single, screen_multi, ball_enable, game_over;
    logic [1:0]      serve_player, winner;
    logic [NP*SW-1:0] score;
    logic [2:0]      state_dbg;

    game_flow_ctl #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN),
        .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
    ) dut (
        .clk65MHz(clk), .rst(rst), .frame_tick(frame_tick), .mode_sel(mode_sel),
        .start(start), .point_valid(point_valid), .point_player(point_player),
        .screen_idle(screen_idle), .screen_single(screen_single),
        .screen_multi(screen_multi), .ball_enable(ball_enable),
        .serve_player(serve_player), .score(score), .game_over(game_over),
        .winner(winner), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int idle;
        int single;
        int multi;
        int ball;
        int over;
        int serve;
        int winner;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: match rules in plain integers.
    int m_st = IDLE, m_mode = 0, m_left = 0, m_serve = 0, m_win = 0;
    int m_sc[NP];
    bit m_prev = 1'b1;   // "start was high": nothing counts until start is seen low

    task automatic model_reset();
        m_st = IDLE; m_mode = 0; m_left = 0; m_serve = 0; m_win = 0;
        for (int i = 0; i < NP; i++) m_sc[i] = 0;
        m_prev = 1'b1;
    endtask

    task automatic model_step(input bit r, input bit tick, input int mode,
                              input bit s, input bit pv, input int pp);
        bit edge_s, legal;
        if (!r) begin
            model_reset();
            return;
        end
        edge_s = s && !m_prev;
        m_prev = s;
        legal  = (mode == 1) || (mode == 2);
        if ((m_st == SERVE || m_st == PLAY || m_st == POINT) && !legal) begin
            m_st = IDLE;
            return;
        end
        case (m_st)
            IDLE: if (edge_s && legal) begin
                m_st = SERVE; m_mode = mode; m_left = SF;
                m_serve = 0; m_win = 0;
                for (int i = 0; i < NP; i++) m_sc[i] = 0;
            end
            SERVE: if (tick) begin
                m_left--;
                if (m_left == 0) m_st = PLAY;
            end
            PLAY: if (pv && pp < NP) begin
                m_sc[pp]++;
                m_serve = (pp + 1) % NP;
                if (m_sc[pp] == WIN) begin
                    m_st = OVER; m_win = pp;
                end else begin
                    m_st = POINT; m_left = PF;
                end
            end
            POINT: if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_st = SERVE; m_left = SF;
                end
            end
            OVER: if (edge_s) m_st = IDLE;
            default: m_st = IDLE;
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   sel;
        sel      = (m_st != IDLE) && (m_st != OVER);
        e.st     = m_st;
        e.idle   = sel ? 0 : 1;
        e.single = (sel && m_mode == 1) ? 1 : 0;
        e.multi  = (sel && m_mode == 2) ? 1 : 0;
        e.ball   = (m_st == PLAY) ? 1 : 0;
        e.over   = (m_st == OVER) ? 1 : 0;
        e.serve  = m_serve;
        e.winner = m_win;
        e.score  = 0;
        for (int i = 0; i < NP; i++) e.score += m_sc[i] << (i * SW);
        return e;
    endfunction

    task automatic drive(input bit r, input bit tick, input int mode,
                         input bit s, input bit pv, input int pp);
        @(negedge clk);
        rst          = r;
        frame_tick   = tick;
        mode_sel     = mode[1:0];
        start        = s;
        point_valid  = pv;
        point_player = pp[1:0];
        model_step(r, tick, mode, s, pv, pp);
        exp_q.push_back(model_out());
    endtask

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",  int'(state_dbg),     e.st);
                chk("idle",   int'(screen_idle),   e.idle);
                chk("single", int'(screen_single), e.single);
                chk("multi",  int'(screen_multi),  e.multi);
                chk("ball",   int'(ball_enable),   e.ball);
                chk("over",   int'(game_over),     e.over);
                chk("serve",  int'(serve_player),  e.serve);
                chk("score",  int'(score),         e.score);
                if (e.over == 1) chk("winner", int'(winner), e.winner);
            end
        end
    end

    // One full rally: serve hold, point by pp, post-point pause.
    task automatic play_point(input int mode, input int pp);
        repeat (SF) drive(1, 1, mode, 0, 0, 0);
        drive(1, 0, mode, 0, 1, pp);
        repeat (PF) drive(1, 1, mode, 0, 0, 0);
    endtask

    initial begin
        int  mode_cur;
        bit  s_cur;
        model_reset();

        // Reset with start held high, then release with start still high.
        repeat (3) drive(0, 0, 1, 1, 0, 0);
        repeat (3) drive(1, 0, 1, 1, 0, 0);
        // Real rising edge: single-player match.
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0);
        drive(1, 0, 1, 1, 1, 1);              // point during SERVE ignored
        repeat (SF) drive(1, 1, 1, 1, 0, 0);  // -> PLAY
        drive(1, 0, 1, 1, 1, 3);              // nonexistent player ignored
        drive(1, 1, 2, 1, 1, 1);              // point + tick, mode 2 ignored
        repeat (PF) drive(1, 1, 2, 1, 0, 0);  // -> SERVE
        drive(1, 0, 1, 0, 0, 0);
        // Player 0 from 0 to the winning score.
        for (int k = 0; k < WIN; k++) play_point(1, 0);
        drive(1, 0, 1, 1, 0, 0);              // acknowledge -> IDLE, scores kept
        drive(1, 0, 1, 1, 0, 0);
        // Multi-player match, aborted together with a point.
        drive(1, 0, 2, 0, 0, 0);
        drive(1, 0, 2, 1, 0, 0);
        repeat (SF) drive(1, 1, 2, 1, 0, 0);
        drive(1, 0, 2, 1, 1, 2);
        repeat (PF) drive(1, 1, 2, 1, 0, 0);
        repeat (SF) drive(1, 1, 2, 1, 0, 0);
        drive(1, 0, 0, 1, 1, 0);              // abort wins over the point
        drive(1, 0, 0, 1, 0, 0);
        // New match; reset in the middle of the post-point pause.
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0);
        repeat (SF) drive(1, 1, 1, 1, 0, 0);
        drive(1, 0, 1, 1, 1, 2);
        repeat (45) drive(1, 1, 1, 1, 0, 0);
        repeat (2) drive(0, 1, 1, 1, 0, 0);
        repeat (3) drive(1, 1, 1, 1, 0, 0);

        // Randomised play.
        mode_cur = 1;
        s_cur    = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            bit r, tick, pv;
            int pp;
            r    = ($urandom % 8000) != 0;
            tick = ($urandom % 10) < 9;
            if ($urandom % 10000 == 0) mode_cur = $urandom % 4;
            else if ((mode_cur == 0 || mode_cur == 3) && ($urandom % 20 == 0))
                mode_cur = 1 + ($urandom % 2);
            else if ($urandom % 500 == 0) mode_cur = 3 - mode_cur;
            if ($urandom % 40 == 0) s_cur = ~s_cur;
            pv = ($urandom % 4) == 0;
            pp = ($urandom % 2) ? 0 : int'($urandom % 4);
            drive(r, tick, mode_cur, s_cur, pv, pp);
        end

        // Drain: every expectation must have been compared.
        repeat (4) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
